// File: rtl/gbpt_update_rmw_pkg.sv
// Shared types and constants for the global branch prediction table writer.
// Holds the block/counter types, the pipeline request structs and the index hash.
package gbpt_update_rmw_pkg;

  localparam int GH_LENGTH        = 12;
  localparam int GBPT_SETS        = 1024;
  localparam int ASID_WIDTH       = 9;
  localparam int GBPT_INDEX_WIDTH = $clog2(GBPT_SETS);
  localparam int GBPT_WAYS        = 4;
  localparam int GBPT_WAY_WIDTH   = $clog2(GBPT_WAYS);

  typedef logic [GBPT_INDEX_WIDTH-1:0] gbpt_set_t;
  typedef logic [GBPT_WAY_WIDTH-1:0]   gbpt_way_t;
  typedef logic [1:0]                  gbpt_2bc_t;
  // Counter w lives at bits [2w+1:2w].
  typedef gbpt_2bc_t [GBPT_WAYS-1:0]   gbpt_block_t;

  localparam gbpt_block_t GBPT_INIT_BLOCK = 8'h55;

  typedef enum logic {ST_INIT, ST_READY} gbpt_state_e;

  typedef struct packed {
    gbpt_set_t idx;
    gbpt_way_t way;
    logic      taken;
  } gbpt_upd_req_t;

  typedef struct packed {
    gbpt_set_t   idx;
    gbpt_block_t block;
  } gbpt_wr_t;

  function automatic logic [GH_LENGTH-1:0] gbpt_hash(
    input logic [GH_LENGTH-1:0]  pc_bits,
    input logic [GH_LENGTH-1:0]  gh,
    input logic [ASID_WIDTH-1:0] asid
  );
    return pc_bits ^ gh ^ {{(GH_LENGTH-ASID_WIDTH){1'b0}}, asid};
  endfunction

endpackage

// File: rtl/gbpt_update_rmw_sat_2bc.sv
// Saturating 2-bit counter step: taken counts up to 3, not-taken counts down to 0.
// Purely combinational so it can be dropped into any table writer.
module sat_2bc_update
  import gbpt_update_rmw_pkg::*;
(
  input  gbpt_2bc_t ctr,
  input  logic      taken,
  output gbpt_2bc_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken && ctr != 2'b11)
      ctr_next = ctr + 2'b01;
    else if (!taken && ctr != 2'b00)
      ctr_next = ctr - 2'b01;
  end

endmodule

// File: rtl/gbpt_update_rmw.sv
// GBPT write side: counter array, reset-time init sweep, 2-stage training RMW
// pipeline with S2->S1 forwarding, and a registered write-first block read port.
module gbpt_update_rmw
  import gbpt_update_rmw_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  init_done,
  input  logic                  update_valid,
  input  logic [31:0]           update_PC,
  input  logic [GH_LENGTH-1:0]  update_GH,
  input  logic [ASID_WIDTH-1:0] update_ASID,
  input  logic                  update_taken,
  input  logic                  rd_valid,
  input  gbpt_set_t             rd_set,
  output logic                  rd_resp_valid,
  output gbpt_block_t           rd_resp_block
);

  localparam int        STAGES   = 2;
  localparam gbpt_set_t LAST_SET = gbpt_set_t'(GBPT_SETS - 1);

  gbpt_state_e          state_q, state_d;
  gbpt_set_t            sweep_q;
  logic [STAGES-1:0]    vld_pipe;
  gbpt_upd_req_t        s1_q;
  gbpt_wr_t             s2_q;
  gbpt_block_t          mem [GBPT_SETS];

  logic                 accept;
  logic [GH_LENGTH-1:0] entry;
  gbpt_block_t          s1_old, s1_new;
  gbpt_2bc_t [GBPT_WAYS-1:0] lane_next;
  logic                 wr_en;
  gbpt_set_t            wr_idx;
  gbpt_block_t          wr_data;
  logic                 unused_pc;

  assign unused_pc = ^{update_PC[31:GH_LENGTH+1], update_PC[0]};
  assign accept    = update_valid & init_done;
  assign entry     = gbpt_hash(update_PC[GH_LENGTH:1], update_GH, update_ASID);

  // Init sweep FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (sweep_q == LAST_SET) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_q == ST_INIT && sweep_q != LAST_SET)
        sweep_q <= sweep_q + 1'b1;
      init_done <= (state_d == ST_READY);
    end
  end

  // Update pipeline: S1 captures the hashed request, S2 holds the modified block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], accept};
      if (accept)
        s1_q <= '{idx: entry[GH_LENGTH-1:GBPT_WAY_WIDTH],
                  way: entry[GBPT_WAY_WIDTH-1:0],
                  taken: update_taken};
      if (vld_pipe[0])
        s2_q <= '{idx: s1_q.idx, block: s1_new};
    end
  end

  // S2 has not reached the array yet, so a same-set S1 must take its block.
  assign s1_old = (vld_pipe[1] && s2_q.idx == s1_q.idx) ? s2_q.block : mem[s1_q.idx];

  for (genvar w = 0; w < GBPT_WAYS; w++) begin : g_lane
    sat_2bc_update u_sat (
      .ctr      (s1_old[w]),
      .taken    (s1_q.taken),
      .ctr_next (lane_next[w])
    );
  end

  always_comb begin
    s1_new = s1_old;
    for (int w = 0; w < GBPT_WAYS; w++)
      if (s1_q.way == gbpt_way_t'(w)) s1_new[w] = lane_next[w];
  end

  // Single write port: sweep owns it in INIT, S2 in READY; they never overlap.
  always_comb begin
    wr_en   = vld_pipe[1];
    wr_idx  = s2_q.idx;
    wr_data = s2_q.block;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_q;
      wr_data = GBPT_INIT_BLOCK;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_resp_valid <= 1'b0;
      rd_resp_block <= '0;
    end else begin
      rd_resp_valid <= rd_valid & init_done;
      if (rd_valid)
        rd_resp_block <= (vld_pipe[1] && s2_q.idx == rd_set) ? s2_q.block : mem[rd_set];
    end
  end

endmodule

// File: tb/tb_gbpt_update_rmw.sv
// Self-checking bench for gbpt_update_rmw: directed init/update/hash/reset steps
// followed by random traffic checked against a latency-queue table model.
module tb_gbpt_update_rmw;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_done;
  logic        update_valid = 1'b0;
  logic [31:0] update_PC = '0;
  logic [11:0] update_GH = '0;
  logic [8:0]  update_ASID = '0;
  logic        update_taken = 1'b0;
  logic        rd_valid = 1'b0;
  logic [9:0]  rd_set = '0;
  logic        rd_resp_valid;
  logic [7:0]  rd_resp_block;

  gbpt_update_rmw dut (
    .CLK           (CLK),
    .RST           (RST),
    .init_done     (init_done),
    .update_valid  (update_valid),
    .update_PC     (update_PC),
    .update_GH     (update_GH),
    .update_ASID   (update_ASID),
    .update_taken  (update_taken),
    .rd_valid      (rd_valid),
    .rd_set        (rd_set),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_block (rd_resp_block)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int entry;
    bit taken;
  } pend_t;

  int         checks = 0;
  int         failures = 0;
  int         ecount = 0;
  bit         ready = 0;
  logic [7:0] model [1024];
  pend_t      pend [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A trained entry bumps one 2-bit field of its 8-bit block, clamped to 0..3.
  task automatic model_apply(input int entry, input bit taken);
    int s, w, c;
    s = entry / 4;
    w = entry % 4;
    c = (model[s] >> (2 * w)) & 3;
    c = taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    model[s] = (model[s] & ~(8'd3 << (2 * w))) | 8'(c << (2 * w));
  endtask

  task automatic model_init();
    for (int s = 0; s < 1024; s++) model[s] = 8'h55;
  endtask

  // One clock: drive at negedge, account at posedge, check at the next negedge.
  task automatic cycle(input bit uv, input logic [31:0] pc, input logic [11:0] gh,
                       input logic [8:0] asid, input bit tk, input bit rv, input logic [9:0] rs);
    bit         exp_v;
    logic [7:0] exp_b;
    int         entry;
    update_valid = uv; update_PC = pc; update_GH = gh; update_ASID = asid;
    update_taken = tk; rd_valid = rv; rd_set = rs;
    @(posedge CLK);
    ecount++;
    // Updates accepted two edges ago land in the array at this edge.
    while (pend.size() > 0 && pend[0].cyc <= ecount - 2) begin
      model_apply(pend[0].entry, pend[0].taken);
      void'(pend.pop_front());
    end
    exp_v = rv && ready;
    exp_b = model[rs];
    if (uv && ready) begin
      entry = int'(pc[12:1] ^ gh ^ {3'b000, asid});
      pend.push_back('{cyc: ecount, entry: entry, taken: tk});
    end
    @(negedge CLK);
    if (rv) begin
      chk("rd_resp_valid", {31'd0, rd_resp_valid}, {31'd0, exp_v});
      if (exp_v) chk("rd_model", {24'd0, rd_resp_block}, {24'd0, exp_b});
    end
    update_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(0, 32'd0, 12'd0, 9'd0, 0, 0, 10'd0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [11:0] gh, input logic [8:0] asid, input bit tk);
    cycle(1, pc, gh, asid, tk, 0, 10'd0);
  endtask

  task automatic rd(input logic [9:0] s, input string tag, input logic [7:0] exp);
    cycle(0, 32'd0, 12'd0, 9'd0, 0, 1, s);
    chk(tag, {24'd0, rd_resp_block}, {24'd0, exp});
  endtask

  // Reset just released at a negedge; sweep runs GBPT_SETS edges.
  task automatic run_init();
    for (int i = 1; i <= 1024; i++) begin
      cycle(i == 200, 32'h4, 12'd0, 9'd0, 1, i == 300, 10'd0);
      if (i == 1023) chk("init_done_early", {31'd0, init_done}, 32'd0);
      if (i == 1024) chk("init_done_rise", {31'd0, init_done}, 32'd1);
    end
    model_init();
    ready = 1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    pend.delete();
    ready = 0;
    #1;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rd_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    model_init();
    repeat (3) @(negedge CLK);
    chk("reset_init_done", {31'd0, init_done}, 32'd0);
    chk("reset_rd_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
    chk("reset_rd_resp_block", {24'd0, rd_resp_block}, 32'h00);
    RST = 1'b0;
    run_init();

    rd(10'd0, "init_set0", 8'h55);
    rd(10'd511, "init_set511", 8'h55);
    rd(10'd1023, "init_set1023", 8'h55);

    // Single taken update to set 0 way 2; read lands in S2's write cycle.
    upd(32'h4, 12'd0, 9'd0, 1);
    idle();
    rd(10'd0, "single_update", 8'h65);

    upd(32'h4, 12'd0, 9'd0, 1);
    upd(32'h4, 12'd0, 9'd0, 1);
    idle(); idle();
    rd(10'd0, "fwd_two_taken", 8'h75);

    repeat (3) upd(32'h4, 12'd0, 9'd0, 1);
    idle(); idle();
    rd(10'd0, "sat_high", 8'h75);

    repeat (4) upd(32'h4, 12'd0, 9'd0, 0);
    idle(); idle();
    rd(10'd0, "sat_low", 8'h45);

    upd(32'h4, 12'h003, 9'h004, 1);
    idle(); idle();
    rd(10'd1, "hash_set1", 8'h59);
    rd(10'd0, "hash_set0_kept", 8'h45);

    upd(32'h4, 12'd0, 9'd0, 1);
    idle();
    rd(10'd0, "write_first", 8'h55);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 1,
            12'($urandom_range(0, 7)), 9'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 3)));
    end

    // Reset mid-operation, then again 500 cycles into the fresh sweep.
    upd(32'h4, 12'd0, 9'd0, 1);
    pulse_reset();
    for (int i = 1; i <= 500; i++) begin
      idle();
      if (i == 500) chk("init_mid_sweep", {31'd0, init_done}, 32'd0);
    end
    pulse_reset();
    run_init();
    rd(10'd0, "reinit_set0", 8'h55);
    rd(10'd2, "reinit_set2", 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
